motor_pwm_ramp_gen: RTL

MOTOR_PWM_RAMP_GEN -- requirements
Module: motor_pwm_ramp_gen

---
 rtl/motor_pwm_ramp_gen.sv | 124 ++++++++++++
 1 files changed

// File: rtl/motor_pwm_ramp_gen.sv
// Motor PWM generator: prescaled tick counter, per-period duty ramp toward a
// command-derived target, and an IDLE/RUN/FAULT supervisor that gates the drive.
module motor_pwm_ramp_gen #(
  parameter int IN_W      = 10,
  parameter int PRESCALE  = 16,
  parameter int PERIOD    = 531,
  parameter int OFFSET    = 250,
  parameter int RAMP_STEP = 4
) (
  input  logic            CLOCK_50,
  input  logic            RESET_N,
  input  logic [IN_W-1:0] PWMinput,
  input  logic            enable,
  input  logic            fault_in,
  input  logic            fault_clr,
  output logic            PWMout,
  output logic            period_start,
  output logic [15:0]     duty_active,
  output logic            ramping,
  output logic            fault_active
);

  localparam int              PS_W      = $clog2(PRESCALE + 1);
  localparam logic [PS_W-1:0] PS_LAST   = PS_W'(PRESCALE - 1);
  localparam logic [15:0]     TC_LAST   = 16'(PERIOD - 1);
  localparam logic [16:0]     PERIOD_17 = 17'(PERIOD);
  localparam logic [16:0]     OFFSET_17 = 17'(OFFSET);
  localparam logic [16:0]     STEP_17   = 17'(RAMP_STEP);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } state_t;

  state_t          state;
  state_t          state_n;
  logic [PS_W-1:0] presc_cnt;
  logic [15:0]     tick_count;
  logic [15:0]     target_latched;
  logic [15:0]     target;
  logic [15:0]     duty_ramped;
  logic [16:0]     cmd_sum;
  logic [16:0]     duty_stepped;
  logic            tick;
  logic            wrap;

  // Tick is a clock enable, so the whole block stays on CLOCK_50.
  assign tick = (presc_cnt == PS_LAST);
  assign wrap = tick && (tick_count == TC_LAST);

  // NOTE: sequential state is written with <= only, so every register samples
  // the pre-edge values of its neighbours regardless of statement order.
  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      presc_cnt    <= '0;
      tick_count   <= '0;
      period_start <= 1'b0;
    end else begin
      presc_cnt    <= tick ? '0 : presc_cnt + PS_W'(1);
      period_start <= wrap;
      if (tick) begin
        tick_count <= (tick_count == TC_LAST) ? '0 : tick_count + 16'd1;
      end
    end
  end

  // NOTE: every combinational output gets a default before any branch, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    cmd_sum = 17'(PWMinput) + OFFSET_17;
    target  = '0;
    if (enable && (PWMinput != '0)) begin
      target = (cmd_sum > PERIOD_17) ? PERIOD_17[15:0] : cmd_sum[15:0];
    end
  end

  // Downward moves land immediately; upward moves are limited to RAMP_STEP.
  always_comb begin
    duty_stepped = {1'b0, duty_active} + STEP_17;
    duty_ramped  = target;
    if ((target >= duty_active) && (duty_stepped < {1'b0, target})) begin
      duty_ramped = duty_stepped[15:0];
    end
  end

  always_comb begin
    state_n = state;
    if (fault_in) begin
      state_n = FAULT;
    end else begin
      unique case (state)
        IDLE:    if (target != '0) state_n = RUN;
        RUN:     if (wrap && (target == '0)) state_n = IDLE;
        FAULT:   if (fault_clr) state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      state          <= IDLE;
      duty_active    <= '0;
      target_latched <= '0;
      PWMout         <= 1'b0;
    end else begin
      state  <= state_n;
      // fault_in is folded in so the drive drops on the very next edge.
      PWMout <= (state == RUN) && !fault_in && (tick_count < duty_active);
      if (state_n != RUN) begin
        duty_active    <= '0;
        target_latched <= '0;
      end else if ((state == RUN) && wrap) begin
        duty_active    <= duty_ramped;
        target_latched <= target;
      end
    end
  end

  assign ramping      = (state == RUN) && (duty_active < target_latched);
  assign fault_active = (state == FAULT);

endmodule
